// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with run-time almost-full/almost-empty thresholds, occupancy count,
// sticky overflow/underflow flags and a build-time standard-read or FWFT output.
module sync_fifo_prog #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 6,
  parameter bit FWFT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  input  logic [ASIZE:0]   af_thresh,
  input  logic [ASIZE:0]   ae_thresh,
  input  logic             clr_err,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);
  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE-1:0] waddr, raddr;
  logic [ASIZE:0]   count_next;
  logic             we, re;

  // Gate on the registered flags so a full/empty FIFO never corrupts itself.
  assign we = winc & ~wfull;
  assign re = rinc & ~rempty;

  always_comb begin
    count_next = count + {{ASIZE{1'b0}}, we} - {{ASIZE{1'b0}}, re};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr        <= '0;
      raddr        <= '0;
      count        <= '0;
      wfull        <= 1'b0;
      rempty       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (we) waddr <= waddr + 1'b1;
      if (re) raddr <= raddr + 1'b1;
      count        <= count_next;
      wfull        <= (count_next == (ASIZE+1)'(DEPTH));
      rempty       <= (count_next == '0);
      almost_full  <= (count_next >= af_thresh);
      almost_empty <= (count_next <= ae_thresh);
      // Set takes priority over a same-edge clear.
      overflow     <= (winc & wfull)  | (overflow  & ~clr_err);
      underflow    <= (rinc & rempty) | (underflow & ~clr_err);
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (FWFT) begin : g_fwft
      assign rdata = mem[raddr];
    end else begin : g_reg
      logic [DSIZE-1:0] rd_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     rd_q <= '0;
        else if (re) rd_q <= mem[raddr];
      end
      assign rdata = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench: A = ASIZE 2 standard read, B = ASIZE 3 FWFT.
module tb_sync_fifo_prog;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;

  logic [7:0] a_wdata = '0, a_rdata, b_wdata = '0, b_rdata;
  logic a_winc = 0, a_rinc = 0, a_clr = 0, b_winc = 0, b_rinc = 0, b_clr = 0;
  logic [2:0] a_af = 3'd4, a_ae = 3'd0, a_count;
  logic [3:0] b_af = 4'd6, b_ae = 4'd1, b_count;
  logic a_wfull, a_rempty, a_afl, a_ael, a_ovf, a_udf;
  logic b_wfull, b_rempty, b_afl, b_ael, b_ovf, b_udf;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DSIZE(8), .ASIZE(2), .FWFT(1'b0)) u_a (
    .clk(clk), .rst(rst), .wdata(a_wdata), .winc(a_winc), .rinc(a_rinc),
    .af_thresh(a_af), .ae_thresh(a_ae), .clr_err(a_clr), .rdata(a_rdata),
    .wfull(a_wfull), .rempty(a_rempty), .almost_full(a_afl), .almost_empty(a_ael),
    .count(a_count), .overflow(a_ovf), .underflow(a_udf));

  sync_fifo_prog #(.DSIZE(8), .ASIZE(3), .FWFT(1'b1)) u_b (
    .clk(clk), .rst(rst), .wdata(b_wdata), .winc(b_winc), .rinc(b_rinc),
    .af_thresh(b_af), .ae_thresh(b_ae), .clr_err(b_clr), .rdata(b_rdata),
    .wfull(b_wfull), .rempty(b_rempty), .almost_full(b_afl), .almost_empty(b_ael),
    .count(b_count), .overflow(b_ovf), .underflow(b_udf));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    tests++; if (a_count !== 3'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", a_count); end
    tests++; if (a_rempty !== 1'b1 || a_wfull !== 1'b0) begin fails++; $display("FAIL rst_empty_full got %b%b exp 10", a_rempty, a_wfull); end
    tests++; if (a_ael !== 1'b1 || a_afl !== 1'b0) begin fails++; $display("FAIL rst_almost got ae=%b af=%b exp 1 0", a_ael, a_afl); end
    tests++; if (a_ovf !== 1'b0 || a_udf !== 1'b0) begin fails++; $display("FAIL rst_err got %b%b exp 00", a_ovf, a_udf); end
    tests++; if (a_rdata !== 8'h00) begin fails++; $display("FAIL rst_rdata got %h exp 00", a_rdata); end
    rst = 1'b0;
    tick();
    tests++; if (b_ael !== 1'b1 || b_afl !== 1'b0 || b_rempty !== 1'b1) begin fails++; $display("FAIL rst_idle_b got ae=%b af=%b e=%b exp 1 0 1", b_ael, b_afl, b_rempty); end
  endtask

  task automatic test_fill_drain();
    logic [7:0] exp_d;
    for (int i = 0; i < 4; i++) begin
      a_winc = 1; a_wdata = 8'hA0 + 8'(i); tick();
    end
    a_winc = 0;
    tests++; if (a_wfull !== 1'b1 || a_count !== 3'd4) begin fails++; $display("FAIL fill_full got f=%b c=%0d exp 1 4", a_wfull, a_count); end
    a_winc = 1; a_wdata = 8'hFF; tick(); a_winc = 0;
    tests++; if (a_ovf !== 1'b1 || a_count !== 3'd4) begin fails++; $display("FAIL fill_ovf got o=%b c=%0d exp 1 4", a_ovf, a_count); end
    for (int i = 0; i < 4; i++) begin
      a_rinc = 1; tick();
      exp_d = 8'hA0 + 8'(i);
      tests++; if (a_rdata !== exp_d) begin fails++; $display("FAIL drain_data%0d got %h exp %h", i, a_rdata, exp_d); end
    end
    tests++; if (a_rempty !== 1'b1 || a_count !== 3'd0) begin fails++; $display("FAIL drain_empty got e=%b c=%0d exp 1 0", a_rempty, a_count); end
    tick(); a_rinc = 0;
    tests++; if (a_udf !== 1'b1 || a_rdata !== 8'hA3) begin fails++; $display("FAIL drain_udf got u=%b d=%h exp 1 a3", a_udf, a_rdata); end
    a_clr = 1; tick(); a_clr = 0;
    tests++; if (a_ovf !== 1'b0 || a_udf !== 1'b0) begin fails++; $display("FAIL clr_err got %b%b exp 00", a_ovf, a_udf); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) begin
      a_winc = 1; a_wdata = 8'hB0 + 8'(i); tick();
    end
    a_rinc = 1; a_wdata = 8'hC0; tick();
    tests++; if (a_count !== 3'd3 || a_ovf !== 1'b1 || a_rdata !== 8'hB0) begin fails++; $display("FAIL sim_full got c=%0d o=%b d=%h exp 3 1 b0", a_count, a_ovf, a_rdata); end
    a_winc = 0; a_clr = 1; tick(); a_clr = 0; a_rinc = 0;
    tests++; if (a_count !== 3'd2 || a_rdata !== 8'hB1 || a_ovf !== 1'b0) begin fails++; $display("FAIL sim_pre_mid got c=%0d d=%h o=%b exp 2 b1 0", a_count, a_rdata, a_ovf); end
    a_winc = 1; a_rinc = 1; a_wdata = 8'hC1; tick(); a_winc = 0;
    tests++; if (a_count !== 3'd2 || a_rdata !== 8'hB2) begin fails++; $display("FAIL sim_mid got c=%0d d=%h exp 2 b2", a_count, a_rdata); end
    tick();
    tests++; if (a_rdata !== 8'hB3) begin fails++; $display("FAIL sim_order1 got %h exp b3", a_rdata); end
    tick(); a_rinc = 0;
    tests++; if (a_rdata !== 8'hC1 || a_rempty !== 1'b1) begin fails++; $display("FAIL sim_order2 got d=%h e=%b exp c1 1", a_rdata, a_rempty); end
    a_winc = 1; a_rinc = 1; a_wdata = 8'hC2; tick(); a_winc = 0; a_rinc = 0;
    tests++; if (a_count !== 3'd1 || a_udf !== 1'b1 || a_rdata !== 8'hC1) begin fails++; $display("FAIL sim_empty got c=%0d u=%b d=%h exp 1 1 c1", a_count, a_udf, a_rdata); end
    a_rinc = 1; a_clr = 1; tick(); a_rinc = 0; a_clr = 0;
    tests++; if (a_rdata !== 8'hC2 || a_rempty !== 1'b1 || a_udf !== 1'b0) begin fails++; $display("FAIL sim_empty_rd got d=%h e=%b u=%b exp c2 1 0", a_rdata, a_rempty, a_udf); end
  endtask

  task automatic test_thresholds();
    for (int i = 1; i <= 6; i++) begin
      b_winc = 1; b_wdata = 8'(i); tick(); b_winc = 0;
      tests++; if (b_count !== 4'(i) || b_afl !== (i >= 6) || b_ael !== (i <= 1)) begin fails++; $display("FAIL thr_step%0d got c=%0d af=%b ae=%b", i, b_count, b_afl, b_ael); end
    end
    b_rinc = 1; tick(); b_rinc = 0;
    tests++; if (b_count !== 4'd5 || b_afl !== 1'b0) begin fails++; $display("FAIL thr_c5 got c=%0d af=%b exp 5 0", b_count, b_afl); end
    b_af = 4'd5; #1;
    tests++; if (b_afl !== 1'b0) begin fails++; $display("FAIL thr_before_edge got %b exp 0", b_afl); end
    tick();
    tests++; if (b_afl !== 1'b1 || b_count !== 4'd5) begin fails++; $display("FAIL thr_change got af=%b c=%0d exp 1 5", b_afl, b_count); end
    b_rinc = 1; repeat (5) tick(); b_rinc = 0; b_af = 4'd6; tick();
    tests++; if (b_rempty !== 1'b1 || b_ael !== 1'b1 || b_afl !== 1'b0) begin fails++; $display("FAIL thr_drain got e=%b ae=%b af=%b exp 1 1 0", b_rempty, b_ael, b_afl); end
  endtask

  task automatic test_fwft();
    a_winc = 1; a_wdata = 8'h55; b_winc = 1; b_wdata = 8'h55; tick();
    a_winc = 0; b_winc = 0;
    tests++; if (b_rdata !== 8'h55 || b_rempty !== 1'b0) begin fails++; $display("FAIL fwft1 got d=%h e=%b exp 55 0", b_rdata, b_rempty); end
    tests++; if (a_rdata !== 8'hC2 || a_rempty !== 1'b0) begin fails++; $display("FAIL fwft0_hold got d=%h e=%b exp c2 0", a_rdata, a_rempty); end
    a_rinc = 1; b_rinc = 1; tick(); a_rinc = 0; b_rinc = 0;
    tests++; if (a_rdata !== 8'h55 || a_rempty !== 1'b1) begin fails++; $display("FAIL fwft0_read got d=%h e=%b exp 55 1", a_rdata, a_rempty); end
    tests++; if (b_rempty !== 1'b1) begin fails++; $display("FAIL fwft1_pop got e=%b exp 1", b_rempty); end
  endtask

  task automatic test_wrap();
    a_winc = 1; a_wdata = 8'd0; tick();
    a_rinc = 1;
    for (int i = 0; i < 12; i++) begin
      a_wdata = 8'(i + 1); tick();
      tests++; if (a_rdata !== 8'(i) || a_count !== 3'd1) begin fails++; $display("FAIL wrap%0d got d=%0d c=%0d exp %0d 1", i, a_rdata, a_count, i); end
    end
    a_winc = 0; tick(); a_rinc = 0;
    tests++; if (a_rdata !== 8'd12 || a_rempty !== 1'b1) begin fails++; $display("FAIL wrap_last got d=%0d e=%b exp 12 1", a_rdata, a_rempty); end
  endtask

  task automatic test_reset_mid();
    b_rinc = 1; tick(); b_rinc = 0;
    tests++; if (b_udf !== 1'b1) begin fails++; $display("FAIL rmid_udf got %b exp 1", b_udf); end
    b_winc = 1;
    for (int i = 0; i < 5; i++) begin b_wdata = 8'h10 + 8'(i); tick(); end
    b_winc = 0;
    tests++; if (b_count !== 4'd5) begin fails++; $display("FAIL rmid_c5 got %0d exp 5", b_count); end
    #2 rst = 1'b1; #1;
    tests++; if (b_count !== 4'd0 || b_rempty !== 1'b1 || b_udf !== 1'b0 || b_ovf !== 1'b0) begin fails++; $display("FAIL rmid_async got c=%0d e=%b u=%b o=%b exp 0 1 0 0", b_count, b_rempty, b_udf, b_ovf); end
    rst = 1'b0; tick();
    b_winc = 1; b_wdata = 8'h77; tick(); b_winc = 0;
    tests++; if (b_rdata !== 8'h77 || b_count !== 4'd1) begin fails++; $display("FAIL rmid_new got d=%h c=%0d exp 77 1", b_rdata, b_count); end
    b_rinc = 1; tick(); b_rinc = 0;
    tests++; if (b_rempty !== 1'b1) begin fails++; $display("FAIL rmid_pop got e=%b exp 1", b_rempty); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_thresholds();
    test_fwft();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
